// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: receives a serial stream of samples with a
// frame marker on slot 0 and commits complete frames to channel registers a..d.
module tdm_demux_4ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [1:0]       sel,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    // state  | meaning
    // HUNT   | waiting for a valid beat carrying frame_sync
    // LOCKED | aligned; sel tracks the slot expected next

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       sel_d;
    logic [WIDTH-1:0] s0_q, s1_q, s2_q;
    logic [WIDTH-1:0] s0_d, s1_d, s2_d;
    logic [WIDTH-1:0] a_d, b_d, c_d, d_d;
    logic             frame_valid_d;
    logic             sync_err_d;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel;
        s0_d          = s0_q;
        s1_d          = s1_q;
        s2_d          = s2_q;
        a_d           = a;
        b_d           = b;
        c_d           = c;
        d_d           = d;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        s0_d    = din;
                        sel_d   = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // A sync mid-frame abandons the partial frame and realigns here.
                        sync_err_d = (sel != 2'd0);
                        s0_d       = din;
                        sel_d      = 2'd1;
                    end else begin
                        case (sel)
                            2'd0: begin
                                sync_err_d = 1'b1;
                                sel_d      = 2'd0;
                                state_d    = HUNT;
                            end
                            2'd1: begin
                                s1_d  = din;
                                sel_d = 2'd2;
                            end
                            2'd2: begin
                                s2_d  = din;
                                sel_d = 2'd3;
                            end
                            default: begin
                                a_d           = s0_q;
                                b_d           = s1_q;
                                c_d           = s2_q;
                                d_d           = din;
                                frame_valid_d = 1'b1;
                                sel_d         = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            sel         <= 2'd0;
            s0_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel         <= sel_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            a           <= a_d;
            b           <= b_d;
            c           <= c_d;
            d           <= d_d;
            frame_valid <= frame_valid_d;
            sync_err    <= sync_err_d;
            locked      <= (state_d == LOCKED);
        end
    end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: directed frames plus random traffic, every cycle
// compared against a queue-based frame model.
module tb_tdm_demux_4ch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] a, b, c, d;
    logic [1:0] sel;
    logic       frame_valid, locked, sync_err;

    int n_vec = 0;
    int n_err = 0;

    tdm_demux_4ch #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .a(a), .b(b), .c(c), .d(d), .sel(sel),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is the list of samples collected since the last sync.
    bit         m_locked;
    logic [7:0] m_q[$];
    logic [7:0] m_a, m_b, m_c, m_d;
    bit         m_fv, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_q.delete();
        m_a = 0; m_b = 0; m_c = 0; m_d = 0;
        m_fv = 0; m_err = 0;
    endtask

    task automatic model_beat(input bit v, input bit s, input logic [7:0] x);
        m_fv  = 0;
        m_err = 0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_q = '{x};
                m_locked = 1;
            end
        end else if (s) begin
            if (m_q.size() != 0) m_err = 1;
            m_q = '{x};
        end else if (m_q.size() == 0) begin
            m_err = 1;
            m_locked = 0;
        end else begin
            m_q.push_back(x);
            if (m_q.size() == 4) begin
                m_a = m_q[0]; m_b = m_q[1]; m_c = m_q[2]; m_d = m_q[3];
                m_fv = 1;
                m_q.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("a", 32'(a), 32'(m_a));
        chk("b", 32'(b), 32'(m_b));
        chk("c", 32'(c), 32'(m_c));
        chk("d", 32'(d), 32'(m_d));
        chk("sel", 32'(sel), m_locked ? 32'(m_q.size()) : 32'd0);
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("sync_err", 32'(sync_err), 32'(m_err));
    endtask

    // Called at posedge+1; applies inputs for the next edge, then checks after it.
    task automatic step(input bit v, input bit s, input logic [7:0] x);
        din_valid  = v;
        frame_sync = s;
        din        = x;
        @(posedge clk);
        model_beat(v, s, x);
        #1;
        check_all();
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame(input logic [7:0] x0, x1, x2, x3);
        step(1, 1, x0); step(1, 0, x1); step(1, 0, x2); step(1, 0, x3);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset and basic frame
        step(1, 1, 8'h11);
        chk("tp1_locked", 32'(locked), 32'd1);
        step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
        chk("tp1_fv", 32'(frame_valid), 32'd1);
        chk("tp1_abcd", {a, b, c, d}, 32'h11223344);
        gap(1);
        chk("tp1_fv_drop", 32'(frame_valid), 32'd0);

        // Force HUNT via missing sync, then HUNT discard with gaps
        step(1, 0, 8'hEE);
        for (int i = 0; i < 3; i++) begin step(1, 0, 8'hAA); gap(2); end
        chk("tp2_hunt", 32'(locked), 32'd0);
        step(1, 1, 8'h01); gap(2);
        chk("tp2_sel1", 32'(sel), 32'd1);
        step(1, 0, 8'h02); gap(2);
        step(1, 0, 8'h03); gap(2);
        chk("tp2_sel3", 32'(sel), 32'd3);
        step(1, 0, 8'h04);
        chk("tp2_abcd", {a, b, c, d}, 32'h01020304);
        chk("tp2_sel0", 32'(sel), 32'd0);

        // Early sync
        step(1, 1, 8'h10); step(1, 0, 8'h20); step(1, 1, 8'h30);
        chk("tp3_err", 32'(sync_err), 32'd1);
        chk("tp3_locked", 32'(locked), 32'd1);
        chk("tp3_hold", {a, b, c, d}, 32'h01020304);
        step(1, 0, 8'h40); step(1, 0, 8'h50); step(1, 0, 8'h60);
        chk("tp3_abcd", {a, b, c, d}, 32'h30405060);

        // Missing sync
        frame(8'h01, 8'h02, 8'h03, 8'h04);
        step(1, 0, 8'h05);
        chk("tp4_err", 32'(sync_err), 32'd1);
        chk("tp4_unlock", 32'(locked), 32'd0);
        chk("tp4_hold", {a, b, c, d}, 32'h01020304);
        frame(8'h09, 8'h0A, 8'h0B, 8'h0C);
        chk("tp4_abcd", {a, b, c, d}, 32'h090A0B0C);

        // Back-to-back frames
        for (int f = 0; f < 3; f++) begin
            frame(8'(4*f), 8'(4*f+1), 8'(4*f+2), 8'(4*f+3));
            chk("tp5_fv", 32'(frame_valid), 32'd1);
            chk("tp5_abcd", {a, b, c, d}, {8'(4*f), 8'(4*f+1), 8'(4*f+2), 8'(4*f+3)});
        end

        // Async reset mid-frame
        step(1, 1, 8'h11); step(1, 0, 8'h22);
        din_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("tp6_abcd0", {a, b, c, d}, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 8'h33);
        chk("tp6_locked", 32'(locked), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit v, s;
            v = ($urandom_range(0, 3) != 0);
            s = (m_locked && m_q.size() == 0) ? ($urandom_range(0, 9) != 0)
                                               : ($urandom_range(0, 9) == 0);
            step(v, s, 8'($urandom));
            if (!frame_valid || !sync_err) n_vec++;
            else begin
                n_vec++; n_err++;
                $display("FAIL fv_err_exclusive: both high at %0t", $time);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4ch.md
# tdm_demux_4ch

Four-channel time-division demultiplexer: the receive-side counterpart of the team's 4:1 channel mux. It takes a serial stream of WIDTH-bit samples, one per valid beat, with a frame marker on slot 0. It then distributes the slots to four parallel channel registers a, b, c and d, committing all four together once a complete, correctly aligned frame has been received. It sits at the far end of a shared link, after the serialising mux, and feeds per-channel consumers.

## Interface

- WIDTH, 8, sample width in bits
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, asynchronous and active-low
- din  input  WIDTH  sample for the current slot
- din_valid  input  1  din carries a sample this cycle
- frame_sync  input  1  marks slot 0; qualified by din_valid, ignored otherwise
- a  output  WIDTH  slot 0 of the last committed frame
- b  output  WIDTH  slot 1 of the last committed frame
- c  output  WIDTH  slot 2 of the last committed frame
- d  output  WIDTH  slot 3 of the last committed frame
- sel  output  2  slot index expected on the next valid beat
- frame_valid  output  1  one-cycle pulse: a..d were just updated
- locked  output  1  high in LOCKED state
- sync_err  output  1  one-cycle pulse: framing error detected

## Operation

- States: HUNT and LOCKED. There is a 2-bit slot counter (driven onto sel) and three WIDTH-bit staging registers s0..s2 for slots 0..2.
- Beats with din_valid=0 are ignored entirely: no state, counter or register change.
- In HUNT:
  - A beat without frame_sync is discarded.
  - A beat with frame_sync writes s0=din, sets sel=1 and moves to LOCKED.
- In LOCKED, for each valid beat:
  - frame_sync=1 and sel=0: normal slot 0. Write s0, set sel=1.
  - frame_sync=0 and sel in 1..2: write s[sel], increment sel.
  - frame_sync=0 and sel=3: commit. a=s0, b=s1, c=s2, d=din. Pulse frame_valid, set sel=0.
  - frame_sync=1 and sel≠0: early sync. Pulse sync_err and discard the partial frame (no commit). Realign on this beat: write s0=din, set sel=1, stay LOCKED.
  - frame_sync=0 and sel=0: missing sync. Pulse sync_err, discard the beat, set sel=0 and return to HUNT.
- a..d change only on a commit. Between commits they hold the previous frame's values.
- frame_valid and sync_err are never asserted in the same cycle.

## Timing

- All outputs are registered and reset to 0: a, b, c, d, sel, frame_valid, locked and sync_err. The state resets to HUNT and s0..s2 reset to 0.
- Reset is asynchronous: outputs clear immediately on rst_n falling, independent of clk.
- Reset mid-frame discards all staged data. The first valid beat after rst_n rises is treated as in HUNT.
- Latency: the commit edge is the rising edge that samples the slot-3 beat.
  - a..d and frame_valid=1 become visible in the cycle after that beat.
  - frame_valid drops after one cycle unless the next beat commits again (impossible, because a frame takes ≥4 beats).
- sync_err is visible in the cycle after the offending beat and lasts one cycle.
- locked rises in the cycle after the HUNT sync beat. It falls in the cycle after a missing-sync beat. It stays high through an early-sync realignment.
- sel updates in the cycle after each valid beat and wraps 3→0 on commit.
- Throughput: one sample per cycle. Back-to-back frames produce frame_valid every 4th cycle.
- Idle gaps (din_valid=0) of any length within a frame are tolerated with no error.

## Test plan

- **Reset and basic frame.** Assert rst_n=0, then release. Send a continuous 4-beat frame 0x11(sync), 0x22, 0x33, 0x44. Required: frame_valid pulses once, the cycle after the 0x44 beat, with a=0x11, b=0x22, c=0x33, d=0x44. locked=1 from the cycle after the first beat. sync_err never asserts.
- **HUNT discard and gaps.** Send three non-sync beats 0xAA, then frame 0x01(sync), 0x02, 0x03, 0x04, with din_valid=0 for 2 cycles between each beat. Required: no output change until commit, then a..d=0x01..0x04. sel steps 1, 2, 3, 0 only on valid beats.
- **Early sync.** Send 0x10(sync), 0x20, then 0x30 with frame_sync=1, then 0x40, 0x50, 0x60. Required:
  - sync_err pulses after the 0x30 beat, with no commit for the partial frame.
  - locked stays 1.
  - Commit after 0x60 gives a=0x30, b=0x40, c=0x50, d=0x60.
- **Missing sync.** After one good frame (0x01..0x04), send 0x05 with no sync. Required: sync_err pulse, locked falls to 0, sel=0, and a..d still 0x01..0x04. A following frame 0x09(sync)..0x0C commits normally.
- **Back-to-back frames.** Send 3 continuous frames of incrementing data 0x00..0x0B. Required: frame_valid on every 4th cycle, with a..d = {0,1,2,3}, then {4,5,6,7}, then {8,9,A,B}.
- **Async reset mid-frame.** Send 0x11(sync), 0x22, then pulse rst_n low between clock edges. Required: all outputs read 0 before the next clk edge. After release, a non-sync beat 0x33 is discarded and locked stays 0.
